// File: rtl/bus_arbiter_if.sv
// Bundle of master-side and slave-side bus signals around bus_arbiter.
// Names carry the arbiter's direction: i_* flow into the arbiter, o_* flow out of it.
interface bus_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]    i_request;
  logic [NUM_PORTS-1:0]    i_rw;
  logic [NUM_PORTS*32-1:0] i_address;
  logic [NUM_PORTS*32-1:0] i_wdata;
  logic [NUM_PORTS-1:0]    o_ready;
  logic [31:0]             o_rdata;
  logic [NUM_PORTS-1:0]    o_grant;
  logic                    o_bus_request;
  logic                    o_bus_rw;
  logic [31:0]             o_bus_address;
  logic [31:0]             o_bus_wdata;
  logic                    i_bus_ready;
  logic [31:0]             i_bus_rdata;
  logic                    o_timeout;

  // The arbiter acts as the single master the slaves see.
  modport master (
    input  i_request, i_rw, i_address, i_wdata, i_bus_ready, i_bus_rdata,
    output o_ready, o_rdata, o_grant, o_bus_request, o_bus_rw, o_bus_address,
           o_bus_wdata, o_timeout
  );

  modport slave (
    output i_request, i_rw, i_address, i_wdata, i_bus_ready, i_bus_rdata,
    input  o_ready, o_rdata, o_grant, o_bus_request, o_bus_rw, o_bus_address,
           o_bus_wdata, o_timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system bus between NUM_PORTS masters, one transaction at a time.
// Define BUS_ARBITER_TIMEOUT_EN to abort a transaction after TIMEOUT cycles without i_bus_ready.
module bus_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 1024
) (
  input logic           i_clock,
  input logic           i_reset,
  bus_arbiter_if.master bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [PW-1:0]        r_pointer;
  logic [PW-1:0]        r_owner;
  logic [NUM_PORTS-1:0] r_grant;
  logic [PW-1:0]        w_select;
  logic [PW-1:0]        w_cand;
  logic [PW-1:0]        w_nextPointer;
  logic                 w_found;
  logic                 w_done;
  logic                 w_expired;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 2) begin : g_badParams
    $error("bus_arbiter: NUM_PORTS must be 2..8 and TIMEOUT at least 2");
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_count;
  logic          r_timeout;

  assign w_expired = (r_state == GRANT) && !bus.i_bus_ready && (r_count == CW'(TIMEOUT - 1));

  // Counter is held at zero outside GRANT, so every grant starts counting from zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != GRANT) begin
        r_count <= '0;
      end else if (!bus.i_bus_ready && !w_expired) begin
        r_count <= r_count + CW'(1);
      end
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.o_timeout = r_timeout & ~i_reset;
`else
  assign w_expired     = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  assign w_done        = (r_state == GRANT) && (bus.i_bus_ready || w_expired);
  assign w_nextPointer = (r_owner == PW'(NUM_PORTS - 1)) ? '0 : r_owner + PW'(1);

  // First requester at or above the pointer, wrapping around; the last owner ends up lowest.
  always_comb begin
    w_found  = 1'b0;
    w_select = r_pointer;
    w_cand   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = PW'((int'(r_pointer) + k) % NUM_PORTS);
      if (!w_found && bus.i_request[w_cand]) begin
        w_found  = 1'b1;
        w_select = w_cand;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pointer <= '0;
      r_owner   <= '0;
      r_grant   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_found) begin
        r_owner <= w_select;
        r_grant <= NUM_PORTS'(1) << w_select;
      end
      if (w_done) begin
        r_pointer <= w_nextPointer;
        r_grant   <= '0;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = GRANT;
      GRANT:   if (w_done) w_nextState = RELEASE;
      RELEASE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Response path is purely combinational so the arbiter adds no latency to ready/rdata.
  always_comb begin
    bus.o_bus_request = 1'b0;
    bus.o_bus_rw      = 1'b0;
    bus.o_bus_address = '0;
    bus.o_bus_wdata   = '0;
    bus.o_ready       = '0;
    bus.o_rdata       = '0;
    if (!i_reset && r_state == GRANT) begin
      bus.o_bus_request = 1'b1;
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (r_owner == PW'(n)) begin
          bus.o_bus_rw      = bus.i_rw[n];
          bus.o_bus_address = bus.i_address[n*32 +: 32];
          bus.o_bus_wdata   = bus.i_wdata[n*32 +: 32];
          bus.o_ready[n]    = w_done;
        end
      end
      bus.o_rdata = w_expired ? 32'h0 : bus.i_bus_rdata;
    end
  end

  assign bus.o_grant = r_grant & {NUM_PORTS{~i_reset}};
endmodule
